membus_arbiter: RTL and testbench

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

---
 rtl/membus_arbiter_if.sv | 30 +++
 rtl/membus_arbiter.sv | 97 +++++++++
 tb/tb_membus_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/membus_arbiter_if.sv
// Bus bundle between the two requesters (M0 = CPU, M1 = DMA), the arbiter and the single-port DataMemory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface membus_arbiter_if;
  logic        M0_Read,       M1_Read;
  logic        M0_Write,      M1_Write;
  logic        M0_Lock,       M1_Lock;
  logic [31:0] M0_Address,    M1_Address;
  logic [31:0] M0_Write_Data, M1_Write_Data;
  logic        M0_Ready,      M1_Ready;
  logic [31:0] M0_Read_Data,  M1_Read_Data;
  logic        Mem_Read,      Mem_Write;
  logic [31:0] Mem_Address,   Mem_Write_Data;
  logic [31:0] Mem_Read_Data;

  modport slave (
    input  M0_Read, M1_Read, M0_Write, M1_Write, M0_Lock, M1_Lock,
    input  M0_Address, M1_Address, M0_Write_Data, M1_Write_Data,
    input  Mem_Read_Data,
    output M0_Ready, M1_Ready, M0_Read_Data, M1_Read_Data,
    output Mem_Read, Mem_Write, Mem_Address, Mem_Write_Data
  );

  modport master (
    output M0_Read, M1_Read, M0_Write, M1_Write, M0_Lock, M1_Lock,
    output M0_Address, M1_Address, M0_Write_Data, M1_Write_Data,
    output Mem_Read_Data,
    input  M0_Ready, M1_Ready, M0_Read_Data, M1_Read_Data,
    input  Mem_Read, Mem_Write, Mem_Address, Mem_Write_Data
  );
endinterface

// File: rtl/membus_arbiter.sv
// Two-master arbiter for a single-port data memory; one access per cycle, owner routed combinationally.
// Define MEMBUS_ARBITER_RR_EN for round-robin ties and MAX_HOLD preemption; default is fixed M0 priority.
//
// state | meaning
// IDLE  | no owner; arbitrate requests for the next cycle
// OWN0  | M0 (CPU) owns the memory port
// OWN1  | M1 (DMA) owns the memory port
module membus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              reset,
  membus_arbiter_if.slave  bus
);

  localparam int HW = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state;
  logic            last_owner;
  logic [HW-1:0]   hold_cnt;

  logic m0_req, m1_req;
  logic owning, owner;
  logic own_req, own_read, own_write, own_lock, other_req;
  logic xfer, preempt, stay, tie_win, idle_win;

  assign m0_req    = bus.M0_Read | bus.M0_Write;
  assign m1_req    = bus.M1_Read | bus.M1_Write;

  assign owning    = (state == OWN0) || (state == OWN1);
  assign owner     = (state == OWN1);
  assign own_req   = owner ? m1_req      : m0_req;
  assign other_req = owner ? m0_req      : m1_req;
  assign own_read  = owner ? bus.M1_Read  : bus.M0_Read;
  assign own_write = owner ? bus.M1_Write : bus.M0_Write;
  assign own_lock  = owner ? bus.M1_Lock  : bus.M0_Lock;
  assign xfer      = owning & own_req;

`ifdef MEMBUS_ARBITER_RR_EN
  // Counter holds transfers already done in this tenure, so this cycle's transfer is the MAX_HOLD-th.
  assign preempt   = xfer & other_req & (hold_cnt >= HW'(MAX_HOLD - 1));
  assign tie_win   = ~last_owner;
`else
  assign preempt   = 1'b0;
  assign tie_win   = 1'b0;
`endif

  assign stay      = xfer & (own_lock | ~other_req) & ~preempt;
  assign idle_win  = (m0_req & m1_req) ? tie_win : m1_req;

  assign bus.Mem_Write      = xfer & own_write;
  assign bus.Mem_Read       = xfer & own_read & ~own_write;
  assign bus.Mem_Address    = xfer ? (owner ? bus.M1_Address    : bus.M0_Address)    : '0;
  assign bus.Mem_Write_Data = xfer ? (owner ? bus.M1_Write_Data : bus.M0_Write_Data) : '0;
  assign bus.M0_Ready       = xfer & ~owner;
  assign bus.M1_Ready       = xfer & owner;
  assign bus.M0_Read_Data   = (xfer & ~owner) ? bus.Mem_Read_Data : '0;
  assign bus.M1_Read_Data   = (xfer & owner)  ? bus.Mem_Read_Data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req | m1_req) begin
            state      <= idle_win ? OWN1 : OWN0;
            last_owner <= idle_win;
            hold_cnt   <= '0;
          end
        end
        OWN0, OWN1: begin
          if (stay) begin
            if (hold_cnt != HW'(MAX_HOLD))
              hold_cnt <= hold_cnt + 1'b1;
          end else if (other_req) begin
            state      <= owner ? OWN0 : OWN1;
            last_owner <= ~owner;
            hold_cnt   <= '0;
          end else begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// Self-checking bench for membus_arbiter: directed scenarios plus randomized requester agents,
// every cycle compared against a transaction-level ownership model.
module tb_membus_arbiter;

`ifdef MEMBUS_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  membus_arbiter_if bus ();

  membus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who currently holds the port, how many transfers it did this tenure, who was granted last.
  int          gm     = -1;
  int          last   = 1;
  int          streak = 0;
  bit          r[2], w[2], lk[2], rq[2];
  logic [31:0] a[2], d[2];
  logic        e_rdy0, e_rdy1, e_mr, e_mw;
  logic [31:0] e_rd0, e_rd1, e_ma, e_md;
  int          o, y;
  bit          pre;

  always @(negedge clk) begin
    r[0] = bus.M0_Read;  r[1] = bus.M1_Read;
    w[0] = bus.M0_Write; w[1] = bus.M1_Write;
    lk[0] = bus.M0_Lock; lk[1] = bus.M1_Lock;
    a[0] = bus.M0_Address; a[1] = bus.M1_Address;
    d[0] = bus.M0_Write_Data; d[1] = bus.M1_Write_Data;
    rq[0] = r[0] | w[0]; rq[1] = r[1] | w[1];

    e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
    e_mr = 1'b0; e_mw = 1'b0; e_ma = '0; e_md = '0;
    if (!reset && gm >= 0 && rq[gm]) begin
      if (gm == 0) begin e_rdy0 = 1'b1; e_rd0 = bus.Mem_Read_Data; end
      else         begin e_rdy1 = 1'b1; e_rd1 = bus.Mem_Read_Data; end
      e_mw = w[gm];
      e_mr = r[gm] & ~w[gm];
      e_ma = a[gm];
      e_md = d[gm];
    end

    chk("m0_ready",       32'(bus.M0_Ready),  32'(e_rdy0));
    chk("m1_ready",       32'(bus.M1_Ready),  32'(e_rdy1));
    chk("m0_read_data",   bus.M0_Read_Data,   e_rd0);
    chk("m1_read_data",   bus.M1_Read_Data,   e_rd1);
    chk("mem_read",       32'(bus.Mem_Read),  32'(e_mr));
    chk("mem_write",      32'(bus.Mem_Write), 32'(e_mw));
    chk("mem_address",    bus.Mem_Address,    e_ma);
    chk("mem_write_data", bus.Mem_Write_Data, e_md);

    if (reset) begin
      gm = -1; last = 1; streak = 0;
    end else if (gm < 0) begin
      if (rq[0] || rq[1]) begin
        if (rq[0] && rq[1]) gm = RR ? (1 - last) : 0;
        else                gm = rq[1] ? 1 : 0;
        last   = gm;
        streak = 0;
      end
    end else begin
      o = gm; y = 1 - gm;
      if (rq[o]) streak++;
      pre = RR && rq[o] && rq[y] && (streak >= MAX_HOLD);
      if (!(rq[o] && (lk[o] || !rq[y]) && !pre)) begin
        if (rq[y]) begin gm = y; last = y; streak = 0; end
        else       begin gm = -1; streak = 0; end
      end
    end
  end

  task automatic clr_inputs();
    bus.M0_Read = 1'b0; bus.M0_Write = 1'b0; bus.M0_Lock = 1'b0;
    bus.M1_Read = 1'b0; bus.M1_Write = 1'b0; bus.M1_Lock = 1'b0;
    bus.M0_Address = '0; bus.M0_Write_Data = '0;
    bus.M1_Address = '0; bus.M1_Write_Data = '0;
    bus.Mem_Read_Data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    clr_inputs();
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic run_random(input int n);
    bit          busy[2], done[2], brd[2], bwr[2];
    logic [31:0] bad[2], bwd[2];
    int          k;
    busy[0] = 1'b0; busy[1] = 1'b0; done[0] = 1'b0; done[1] = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (busy[m] && done[m]) busy[m] = 1'b0;
        if (!busy[m]) begin
          brd[m] = 1'b0; bwr[m] = 1'b0;
          bad[m] = $urandom; bwd[m] = $urandom;
          if ($urandom_range(2, 0) == 0) begin
            busy[m] = 1'b1;
            k = $urandom_range(7, 0);
            brd[m] = (k == 0) || (k < 4);
            bwr[m] = (k == 0) || (k >= 4);
          end
        end
      end
      bus.M0_Read = brd[0]; bus.M0_Write = bwr[0];
      bus.M0_Address = bad[0]; bus.M0_Write_Data = bwd[0];
      bus.M1_Read = brd[1]; bus.M1_Write = bwr[1];
      bus.M1_Address = bad[1]; bus.M1_Write_Data = bwd[1];
      bus.M0_Lock = ($urandom_range(3, 0) != 0);
      bus.M1_Lock = ($urandom_range(3, 0) != 0);
      bus.Mem_Read_Data = $urandom;
      @(negedge clk);
      done[0] = bus.M0_Ready;
      done[1] = bus.M1_Ready;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int n1, first_m0;

  initial begin
    reset = 1'b1;
    clr_inputs();
    do_reset();

    // Single CPU read: one arbitration cycle, then the transfer.
    bus.M0_Read = 1'b1; bus.M0_Address = 32'h10; bus.Mem_Read_Data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_idle_ready", 32'(bus.M0_Ready), 32'd0);
    chk("t1_idle_mem_read", 32'(bus.Mem_Read), 32'd0);
    @(negedge clk);
    chk("t1_ready", 32'(bus.M0_Ready), 32'd1);
    chk("t1_read_data", bus.M0_Read_Data, 32'hDEADBEEF);
    chk("t1_mem_address", bus.Mem_Address, 32'h10);
    step();
    clr_inputs();

    // Tie after reset: M0 first, M1 immediately after.
    do_reset();
    bus.M0_Read = 1'b1; bus.M0_Address = 32'h100;
    bus.M1_Read = 1'b1; bus.M1_Address = 32'h200;
    bus.Mem_Read_Data = 32'h12345678;
    @(negedge clk);
    chk("t2_idle_m0", 32'(bus.M0_Ready), 32'd0);
    chk("t2_idle_m1", 32'(bus.M1_Ready), 32'd0);
    @(negedge clk);
    chk("t2_m0_first", 32'(bus.M0_Ready), 32'd1);
    chk("t2_m1_waits", 32'(bus.M1_Ready), 32'd0);
    chk("t2_addr0", bus.Mem_Address, 32'h100);
    step();
    bus.M0_Read = 1'b0;
    @(negedge clk);
    chk("t2_m1_next", 32'(bus.M1_Ready), 32'd1);
    chk("t2_addr1", bus.Mem_Address, 32'h200);
    chk("t2_m1_data", bus.M1_Read_Data, 32'h12345678);
    step();
    clr_inputs();

    // Locked DMA writes while CPU waits.
    do_reset();
    bus.M1_Write = 1'b1; bus.M1_Lock = 1'b1;
    bus.M1_Address = 32'h20; bus.M1_Write_Data = 32'h55;
    step();
    bus.M0_Read = 1'b1; bus.M0_Address = 32'h40;
    n1 = 0; first_m0 = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.M1_Ready) n1++;
      if (bus.M0_Ready && first_m0 < 0) first_m0 = c;
      if (first_m0 >= 0) break;
    end
    chk("t3_m1_pulses", n1, RR ? 32'd8 : 32'd20);
    chk("t3_m0_first_grant", first_m0, RR ? 32'd8 : 32'hFFFFFFFF);
    step();
    clr_inputs();

    // Read and write together: write wins.
    do_reset();
    bus.M0_Read = 1'b1; bus.M0_Write = 1'b1;
    bus.M0_Address = 32'h30; bus.M0_Write_Data = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    chk("t4_mem_write", 32'(bus.Mem_Write), 32'd1);
    chk("t4_mem_read", 32'(bus.Mem_Read), 32'd0);
    chk("t4_wdata", bus.Mem_Write_Data, 32'hCAFEF00D);
    chk("t4_ready", 32'(bus.M0_Ready), 32'd1);
    step();
    clr_inputs();

    // Asynchronous reset while DMA owns, then a tie goes to M0.
    do_reset();
    bus.M1_Read = 1'b1; bus.M1_Address = 32'h44; bus.Mem_Read_Data = 32'hA5A5A5A5;
    @(negedge clk);
    @(negedge clk);
    chk("t5_m1_owns", 32'(bus.M1_Ready), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_ready", 32'(bus.M1_Ready), 32'd0);
    chk("t5_async_rdata", bus.M1_Read_Data, 32'd0);
    chk("t5_async_mem_read", 32'(bus.Mem_Read), 32'd0);
    chk("t5_async_mem_addr", bus.Mem_Address, 32'd0);
    step();
    @(negedge clk);
    step();
    reset = 1'b0;
    bus.M0_Read = 1'b1; bus.M0_Address = 32'h48;
    @(negedge clk);
    chk("t5_idle", 32'(bus.M0_Ready), 32'd0);
    @(negedge clk);
    chk("t5_tie_m0", 32'(bus.M0_Ready), 32'd1);
    chk("t5_tie_m1", 32'(bus.M1_Ready), 32'd0);
    step();
    clr_inputs();

    do_reset();
    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
